adv_timer_mch_core: RTL and testbench
=====================================

Name: adv_timer_mch_core

Overview:
Second-generation advanced timer counter core with a single clock and N_CH compare channels (previously fixed at 4).
New relative to the fixed 4-channel core:
- one-shot mode
- up/down (centre-aligned) counting
- per-channel complementary outputs with programmable dead time
- a period-end event
It sits under the timer register file, one instance per timer. External trigger inputs arrive already synchronised to clk_i.

Parameters:
NUM_BITS, 16, counter and compare width (2..32)
N_CH, 4, number of compare/PWM channels (1..8)
N_EXTSIG, 32, number of selectable external inputs
DT_BITS, 8, dead-time counter width

Ports:
clk_i  in  1  core clock
rstn_i  in  1  synchronous active-low reset
cfg_start_i  in  1  pulse: start counting
cfg_stop_i  in  1  pulse: stop, hold counter
cfg_rst_i  in  1  pulse: reload counter with active start value
cfg_update_i  in  1  pulse: request shadow to active copy at next period end
cfg_oneshot_i  in  1  1 = stop automatically after one period
cfg_sel_i  in  $clog2(N_EXTSIG)  trigger input select
cfg_mode_i  in  3  0 free, 1 level high, 2 level low, 3 rise, 4 fall, 5 both edges, 6-7 free
cfg_presc_i  in  8  tick every presc+1 qualified cycles
cfg_sawtooth_i  in  1  1 = up-count saw, 0 = up/down triangle
cfg_cnt_start_i  in  NUM_BITS  shadow start value
cfg_cnt_end_i  in  NUM_BITS  shadow end value
cfg_comp_i  in  N_CH*NUM_BITS  shadow compare values, ch k at [k*NUM_BITS +: NUM_BITS]
cfg_comp_op_i  in  N_CH*3  shadow compare ops
cfg_dt_i  in  DT_BITS  dead-time cycles (shared by all channels)
signal_i  in  N_EXTSIG  external trigger inputs
counter_o  out  NUM_BITS  current count
pwm_o  out  N_CH  high-side outputs
pwm_n_o  out  N_CH  complementary low-side outputs
end_o  out  1  one-cycle pulse at period end
running_o  out  1  FSM in RUN

Behaviour:
- Reset (rstn_i low at posedge clk_i) gives:
  - counter_o = 0, pwm_o = 0, pwm_n_o = 0, end_o = 0, running_o = 0
  - FSM = IDLE, prescaler = 0, direction = up
  - active copies of all shadow values = 0, update pending = 0, edge-detect register = 0
- Reset mid-operation behaves identically; reset has priority over every command.
- FSM states IDLE and RUN:
  - IDLE to RUN on cfg_start_i.
  - RUN to IDLE on cfg_stop_i, or on period end when cfg_oneshot_i = 1.
  - cfg_start_i and cfg_stop_i in the same cycle: stop wins.
- cfg_start_i in IDLE also copies shadow to active and loads counter = active start. running_o is high the following cycle.
- Qualification:
  - sel = signal_i[cfg_sel_i]; prev = registered sel.
  - Modes 3, 4, 5 qualify on rise, fall or any edge, each for one cycle.
  - Modes 1 and 2 qualify every cycle while the level matches.
- Prescaler counts qualified cycles in RUN only. tick = qualified && presc_cnt == cfg_presc_i, then presc_cnt clears. cfg_presc_i = 0 gives tick on every qualified cycle.
- On tick, saw mode:
  - count == end gives period end: count = start.
  - Otherwise count + 1.
- On tick, triangle mode:
  - Counting up: count + 1; on reaching end, direction becomes down.
  - Counting down: count - 1; reaching start is period end, and direction becomes up.
- Arithmetic is modulo 2^NUM_BITS. start > end in saw mode wraps through all-ones to 0 to end. start == end means every tick is a period end.
- end_o pulses in the cycle after the period-end tick.
- On period end with update pending, shadow copies to active (start, end, comp, op) and pending clears.
- cfg_update_i together with period end in the same cycle: applies at this period end.
- cfg_rst_i: counter = active start, presc_cnt = 0, direction = up. No period end is signalled. cfg_rst_i in IDLE is permitted.
- Raw channel output r[k], on tick with count == comp[k]:
  - op 0 SET: r = 1
  - op 1 TOG_CLR: toggle on match, clear at period end
  - op 2 SET_RST: set on match, clear at period end
  - op 3 TOGGLE: toggle on match
  - op 4 RESET: r = 0
  - op 5 TOG_SET: toggle on match, set at period end
  - op 6 RST_SET: clear on match, set at period end
  - op 7: hold
  - When match and period end coincide, the match action applies last.
- Dead time, per channel:
  - When r changes, both pwm_o and pwm_n_o go 0 and the dt counter loads cfg_dt_i.
  - After cfg_dt_i further cycles, pwm_o = r and pwm_n_o = ~r.
  - An r change while counting restarts the count.
  - cfg_dt_i = 0 gives pwm_o = r and pwm_n_o = ~r, registered one cycle after r.
  - pwm_o and pwm_n_o are never both 1.
- Stopping holds r, the outputs and counter_o.

Decomposition:
- Package adv_timer_mch_pkg holds:
  - mode enum, comp-op enum, FSM state enum
  - localparam SEL_W = $clog2(N_EXTSIG)
- Sub-module adv_timer_mch_dt: single-channel dead-time generator (r in; pwm, pwm_n out), generated N_CH times.

Test Plan:
- Saw free-run, start = 0, end = 9, presc = 0, ch0 op SET_RST comp = 5:
  - counter_o cycles 0..9.
  - pwm_o[0] high for counts 5..9.
  - end_o every 10 cycles.
- Triangle, start = 0, end = 4:
  - counter 0,1,2,3,4,3,2,1,0,1...
  - end_o after each return to 0.
  - ch1 TOGGLE comp = 2 toggles twice per period.
- Mode 3 (rise) on signal_i[7], presc = 2:
  - counter increments once per 3 rising edges.
  - No change for steady input or edges on other lines.
- cfg_dt_i = 3 with ch0 toggling:
  - after each r edge both outputs 0 for 3 cycles, then the complementary pair.
  - Assert pwm_o & pwm_n_o never 1.
- One-shot saw, end = 5:
  - exactly one end_o, then running_o = 0.
  - counter_o holds start; a new start restarts.
- Shadow update: change end 9 to 3 with cfg_update_i mid-period:
  - the current period finishes at 9, the next ends at 3.
  - rstn_i low mid-run: all outputs 0 the next cycle.

Source files
------------

// File: rtl/adv_timer_mch_pkg.sv
// Purpose: shared types for the multi-channel advanced timer core.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package adv_timer_mch_pkg;

    localparam int N_EXTSIG_DFLT = 32;
    localparam int SEL_W         = $clog2(N_EXTSIG_DFLT);

    // Trigger qualification modes; 6 and 7 behave as free-running.
    typedef enum logic [2:0] {
        MODE_FREE   = 3'd0,
        MODE_LVL_HI = 3'd1,
        MODE_LVL_LO = 3'd2,
        MODE_RISE   = 3'd3,
        MODE_FALL   = 3'd4,
        MODE_EDGE   = 3'd5,
        MODE_FREE6  = 3'd6,
        MODE_FREE7  = 3'd7
    } mode_e;

    // Compare actions: match action, plus optional action at period end.
    typedef enum logic [2:0] {
        OP_SET     = 3'd0,
        OP_TOG_CLR = 3'd1,
        OP_SET_RST = 3'd2,
        OP_TOGGLE  = 3'd3,
        OP_RESET   = 3'd4,
        OP_TOG_SET = 3'd5,
        OP_RST_SET = 3'd6,
        OP_HOLD    = 3'd7
    } comp_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/adv_timer_mch_dt.sv
// Purpose: single-channel dead-time inserter producing a non-overlapping high/low pair.
// Latency: pair follows r one cycle later when dt is 0, else after dt blanking cycles.
// Backpressure: none; frozen while en_i is low so a stopped timer holds its outputs.
module adv_timer_mch_dt #(
    parameter int DT_BITS = 8
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               en_i,
    input  logic [DT_BITS-1:0] dt_i,
    input  logic               r_i,
    output logic               pwm_o,
    output logic               pwm_n_o
);

    logic               r_seen_q;
    logic [DT_BITS-1:0] dt_cnt_q;

    // Blank both sides on every r change, release the complementary pair once dt has expired.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            r_seen_q <= 1'b0;
            dt_cnt_q <= '0;
            pwm_o    <= 1'b0;
            pwm_n_o  <= 1'b0;
        end else if (en_i) begin
            if (r_i != r_seen_q) begin
                r_seen_q <= r_i;
                if (dt_i == '0) begin
                    dt_cnt_q <= '0;
                    pwm_o    <= r_i;
                    pwm_n_o  <= ~r_i;
                end else begin
                    dt_cnt_q <= dt_i;
                    pwm_o    <= 1'b0;
                    pwm_n_o  <= 1'b0;
                end
            end else if (dt_cnt_q > DT_BITS'(1)) begin
                dt_cnt_q <= dt_cnt_q - DT_BITS'(1);
            end else begin
                dt_cnt_q <= '0;
                pwm_o    <= r_seen_q;
                pwm_n_o  <= ~r_seen_q;
            end
        end
    end

endmodule

// File: rtl/adv_timer_mch_core.sv
// Purpose: timer counter with trigger qualification, prescaler, saw/triangle counting and N_CH compare channels.
// Latency: counter/raw channel state update on the tick edge; end_o one cycle after the period-end tick.
// Backpressure: none; commands are single-cycle pulses, stop wins over start.
module adv_timer_mch_core
    import adv_timer_mch_pkg::*;
#(
    parameter int NUM_BITS = 16,
    parameter int N_CH     = 4,
    parameter int N_EXTSIG = 32,
    parameter int DT_BITS  = 8
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        cfg_start_i,
    input  logic                        cfg_stop_i,
    input  logic                        cfg_rst_i,
    input  logic                        cfg_update_i,
    input  logic                        cfg_oneshot_i,
    input  logic [$clog2(N_EXTSIG)-1:0] cfg_sel_i,
    input  logic [2:0]                  cfg_mode_i,
    input  logic [7:0]                  cfg_presc_i,
    input  logic                        cfg_sawtooth_i,
    input  logic [NUM_BITS-1:0]         cfg_cnt_start_i,
    input  logic [NUM_BITS-1:0]         cfg_cnt_end_i,
    input  logic [N_CH*NUM_BITS-1:0]    cfg_comp_i,
    input  logic [N_CH*3-1:0]           cfg_comp_op_i,
    input  logic [DT_BITS-1:0]          cfg_dt_i,
    input  logic [N_EXTSIG-1:0]         signal_i,
    output logic [NUM_BITS-1:0]         counter_o,
    output logic [N_CH-1:0]             pwm_o,
    output logic [N_CH-1:0]             pwm_n_o,
    output logic                        end_o,
    output logic                        running_o
);

    state_e                     state_q;
    logic [NUM_BITS-1:0]        cnt_q, cnt_nxt;
    logic [NUM_BITS-1:0]        act_start_q, act_end_q;
    logic [N_CH*NUM_BITS-1:0]   act_comp_q;
    logic [N_CH*3-1:0]          act_op_q;
    logic [7:0]                 presc_q;
    logic                       down_q, down_nxt;
    logic                       pend_q;
    logic                       sel, sel_prev_q, qual;
    logic                       running, start_cmd, run_go, tick, wrap_hit, pe, load_shadow;
    logic                       end_pulse_q;
    logic [N_CH-1:0]            r_q, r_nxt;

    assign sel         = signal_i[cfg_sel_i];
    assign running     = (state_q == ST_RUN);
    assign start_cmd   = !running && cfg_start_i && !cfg_stop_i;
    assign run_go      = running && !cfg_stop_i && !cfg_rst_i;
    assign tick        = run_go && qual && (presc_q == cfg_presc_i);
    assign pe          = tick && wrap_hit;
    assign load_shadow = start_cmd || (pe && (pend_q || cfg_update_i));

    // Trigger qualification from the selected line and its previous sample.
    always_comb begin
        case (mode_e'(cfg_mode_i))
            MODE_LVL_HI: qual = sel;
            MODE_LVL_LO: qual = ~sel;
            MODE_RISE:   qual = sel & ~sel_prev_q;
            MODE_FALL:   qual = ~sel & sel_prev_q;
            MODE_EDGE:   qual = sel ^ sel_prev_q;
            default:     qual = 1'b1;
        endcase
    end

    // Next count and direction for a tick; flags whether that tick closes the period.
    always_comb begin
        cnt_nxt  = cnt_q;
        down_nxt = down_q;
        wrap_hit = 1'b0;
        if (cfg_sawtooth_i) begin
            if (cnt_q == act_end_q) begin
                wrap_hit = 1'b1;
                cnt_nxt  = act_start_q;
            end else begin
                cnt_nxt = cnt_q + NUM_BITS'(1);
            end
        end else if (act_start_q == act_end_q) begin
            wrap_hit = 1'b1;
            cnt_nxt  = act_start_q;
            down_nxt = 1'b0;
        end else if (!down_q) begin
            cnt_nxt = cnt_q + NUM_BITS'(1);
            if (cnt_nxt == act_end_q) down_nxt = 1'b1;
        end else begin
            cnt_nxt = cnt_q - NUM_BITS'(1);
            if (cnt_nxt == act_start_q) begin
                wrap_hit = 1'b1;
                down_nxt = 1'b0;
            end
        end
    end

    // Raw channel levels: period-end action first, compare-match action overrides it.
    always_comb begin
        r_nxt = r_q;
        for (int k = 0; k < N_CH; k++) begin
            if (pe) begin
                case (comp_op_e'(act_op_q[k*3 +: 3]))
                    OP_TOG_CLR, OP_SET_RST: r_nxt[k] = 1'b0;
                    OP_TOG_SET, OP_RST_SET: r_nxt[k] = 1'b1;
                    default: ;
                endcase
            end
            if (tick && (cnt_q == act_comp_q[k*NUM_BITS +: NUM_BITS])) begin
                case (comp_op_e'(act_op_q[k*3 +: 3]))
                    OP_SET, OP_SET_RST:                 r_nxt[k] = 1'b1;
                    OP_TOG_CLR, OP_TOGGLE, OP_TOG_SET:  r_nxt[k] = ~r_nxt[k];
                    OP_RESET, OP_RST_SET:               r_nxt[k] = 1'b0;
                    default: ;
                endcase
            end
        end
    end

    // FSM, counter, prescaler, raw channel state and end pulse.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            presc_q     <= '0;
            down_q      <= 1'b0;
            r_q         <= '0;
            sel_prev_q  <= 1'b0;
            end_pulse_q <= 1'b0;
        end else begin
            sel_prev_q  <= sel;
            end_pulse_q <= pe;
            if (start_cmd) begin
                state_q <= ST_RUN;
                cnt_q   <= cfg_cnt_start_i;
                presc_q <= '0;
                down_q  <= 1'b0;
            end else if (running && cfg_stop_i) begin
                state_q <= ST_IDLE;
            end else if (cfg_rst_i) begin
                cnt_q   <= act_start_q;
                presc_q <= '0;
                down_q  <= 1'b0;
            end else if (run_go) begin
                if (qual) presc_q <= (presc_q == cfg_presc_i) ? 8'd0 : presc_q + 8'd1;
                if (tick) begin
                    cnt_q  <= cnt_nxt;
                    down_q <= down_nxt;
                    r_q    <= r_nxt;
                end
                if (pe && cfg_oneshot_i) state_q <= ST_IDLE;
            end
        end
    end

    // Active configuration copies and the pending-update flag.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            act_start_q <= '0;
            act_end_q   <= '0;
            act_comp_q  <= '0;
            act_op_q    <= '0;
            pend_q      <= 1'b0;
        end else if (load_shadow) begin
            act_start_q <= cfg_cnt_start_i;
            act_end_q   <= cfg_cnt_end_i;
            act_comp_q  <= cfg_comp_i;
            act_op_q    <= cfg_comp_op_i;
            pend_q      <= 1'b0;
        end else if (cfg_update_i) begin
            pend_q      <= 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_dt
        adv_timer_mch_dt #(.DT_BITS(DT_BITS)) u_dt (
            .clk_i   (clk_i),
            .rstn_i  (rstn_i),
            .en_i    (running),
            .dt_i    (cfg_dt_i),
            .r_i     (r_q[k]),
            .pwm_o   (pwm_o[k]),
            .pwm_n_o (pwm_n_o[k])
        );
    end

    assign counter_o = cnt_q;
    assign end_o     = end_pulse_q;
    assign running_o = running;

endmodule

// File: tb/tb_adv_timer_mch_core.sv
// Purpose: directed plus randomized checking of adv_timer_mch_core against a cycle-level reference model.
// Latency: outputs sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_adv_timer_mch_core;

    localparam int NB  = 8;
    localparam int NC  = 4;
    localparam int NS  = 32;
    localparam int DTB = 8;

    logic              clk;
    logic              rstn;
    logic              cfg_start, cfg_stop, cfg_rst, cfg_update, cfg_oneshot;
    logic [4:0]        cfg_sel;
    logic [2:0]        cfg_mode;
    logic [7:0]        cfg_presc;
    logic              cfg_saw;
    logic [NB-1:0]     cfg_cs, cfg_ce;
    logic [NC*NB-1:0]  cfg_comp;
    logic [NC*3-1:0]   cfg_op;
    logic [DTB-1:0]    cfg_dt;
    logic [NS-1:0]     sig;
    logic [NB-1:0]     counter;
    logic [NC-1:0]     pwm, pwmn;
    logic              endo, running;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int           m_cnt, m_presc, m_as, m_ae;
    int           m_ac[NC];
    int           m_ao[NC];
    bit           m_run, m_down, m_pend, m_prev, m_end;
    bit           m_r[NC];
    bit           m_pwm[NC];
    bit           m_pwmn[NC];
    logic [NC-1:0] rhist[$];

    adv_timer_mch_core #(.NUM_BITS(NB), .N_CH(NC), .N_EXTSIG(NS), .DT_BITS(DTB)) dut (
        .clk_i          (clk),
        .rstn_i         (rstn),
        .cfg_start_i    (cfg_start),
        .cfg_stop_i     (cfg_stop),
        .cfg_rst_i      (cfg_rst),
        .cfg_update_i   (cfg_update),
        .cfg_oneshot_i  (cfg_oneshot),
        .cfg_sel_i      (cfg_sel),
        .cfg_mode_i     (cfg_mode),
        .cfg_presc_i    (cfg_presc),
        .cfg_sawtooth_i (cfg_saw),
        .cfg_cnt_start_i(cfg_cs),
        .cfg_cnt_end_i  (cfg_ce),
        .cfg_comp_i     (cfg_comp),
        .cfg_comp_op_i  (cfg_op),
        .cfg_dt_i       (cfg_dt),
        .signal_i       (sig),
        .counter_o      (counter),
        .pwm_o          (pwm),
        .pwm_n_o        (pwmn),
        .end_o          (endo),
        .running_o      (running)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic load_active();
        m_as = int'(cfg_cs);
        m_ae = int'(cfg_ce);
        for (int k = 0; k < NC; k++) begin
            m_ac[k] = int'(cfg_comp[k*NB +: NB]);
            m_ao[k] = int'(cfg_op[k*3 +: 3]);
        end
    endtask

    // One clock edge of the specified behaviour, evaluated from the inputs currently applied.
    task automatic model_edge();
        bit s, q, tick, pe, same;
        bit hit[NC];
        logic [NC-1:0] v;
        int n;
        if (!rstn) begin
            m_run = 0; m_cnt = 0; m_presc = 0; m_down = 0; m_pend = 0;
            m_prev = 0; m_end = 0; m_as = 0; m_ae = 0;
            for (int k = 0; k < NC; k++) begin
                m_ac[k] = 0; m_ao[k] = 0; m_r[k] = 0; m_pwm[k] = 0; m_pwmn[k] = 0;
            end
            rhist.delete();
            repeat (16) rhist.push_back('0);
            return;
        end
        s = sig[cfg_sel];
        case (cfg_mode)
            3'd1: q = s;
            3'd2: q = !s;
            3'd3: q = s && !m_prev;
            3'd4: q = !s && m_prev;
            3'd5: q = (s != m_prev);
            default: q = 1'b1;
        endcase
        m_prev = s;
        // dead time: outputs show r only once r has held for dt+1 running samples
        if (m_run) begin
            for (int k = 0; k < NC; k++) v[k] = m_r[k];
            rhist.push_back(v);
            if (rhist.size() > 40) void'(rhist.pop_front());
            n = rhist.size();
            for (int k = 0; k < NC; k++) begin
                same = 1'b1;
                for (int j = 1; j <= int'(cfg_dt); j++)
                    if (rhist[n-1-j][k] != v[k]) same = 1'b0;
                m_pwm[k]  = same && v[k];
                m_pwmn[k] = same && !v[k];
            end
        end
        pe = 0;
        tick = 0;
        if (!m_run) begin
            if (cfg_start && !cfg_stop) begin
                m_run = 1; load_active(); m_cnt = int'(cfg_cs);
                m_presc = 0; m_down = 0; m_pend = 0;
            end else begin
                if (cfg_rst) begin m_cnt = m_as; m_presc = 0; m_down = 0; end
                if (cfg_update) m_pend = 1;
            end
        end else if (cfg_stop) begin
            m_run = 0;
            if (cfg_update) m_pend = 1;
        end else if (cfg_rst) begin
            m_cnt = m_as; m_presc = 0; m_down = 0;
            if (cfg_update) m_pend = 1;
        end else begin
            if (q) begin
                if (m_presc == int'(cfg_presc)) begin tick = 1; m_presc = 0; end
                else m_presc = (m_presc + 1) % 256;
            end
            if (tick) begin
                for (int k = 0; k < NC; k++) hit[k] = (m_cnt == m_ac[k]);
                if (cfg_saw) begin
                    if (m_cnt == m_ae) begin pe = 1; m_cnt = m_as; end
                    else m_cnt = (m_cnt + 1) % 256;
                end else if (m_as == m_ae) begin
                    pe = 1; m_cnt = m_as; m_down = 0;
                end else if (!m_down) begin
                    m_cnt = (m_cnt + 1) % 256;
                    if (m_cnt == m_ae) m_down = 1;
                end else begin
                    m_cnt = (m_cnt + 255) % 256;
                    if (m_cnt == m_as) begin pe = 1; m_down = 0; end
                end
                for (int k = 0; k < NC; k++) begin
                    if (pe) case (m_ao[k])
                        1, 2: m_r[k] = 0;
                        5, 6: m_r[k] = 1;
                        default: ;
                    endcase
                    if (hit[k]) case (m_ao[k])
                        0, 2:    m_r[k] = 1;
                        1, 3, 5: m_r[k] = !m_r[k];
                        4, 6:    m_r[k] = 0;
                        default: ;
                    endcase
                end
            end
            if (pe && (m_pend || cfg_update)) begin load_active(); m_pend = 0; end
            else if (cfg_update) m_pend = 1;
            if (pe && cfg_oneshot) m_run = 0;
        end
        m_end = pe;
    endtask

    task automatic check_all();
        logic [NC-1:0] ep, en;
        for (int k = 0; k < NC; k++) begin ep[k] = m_pwm[k]; en[k] = m_pwmn[k]; end
        check("counter", 32'(counter), 32'(m_cnt));
        check("end_o", 32'(endo), 32'(m_end));
        check("running", 32'(running), 32'(m_run));
        check("pwm", 32'(pwm), 32'(ep));
        check("pwm_n", 32'(pwmn), 32'(en));
        check("overlap", 32'(pwm & pwmn), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
    endtask

    task automatic pulse_start();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic set_ch(input int k, input int c, input int o);
        cfg_comp[k*NB +: NB] = NB'(c);
        cfg_op[k*3 +: 3]     = 3'(o);
    endtask

    task automatic clear_cfg();
        cfg_start = 0; cfg_stop = 0; cfg_rst = 0; cfg_update = 0; cfg_oneshot = 0;
        cfg_sel = '0; cfg_mode = 3'd0; cfg_presc = '0; cfg_saw = 1'b1;
        cfg_cs = '0; cfg_ce = '0; cfg_comp = '0; cfg_op = {NC{3'd7}}; cfg_dt = '0; sig = '0;
    endtask

    task automatic rand_shadow();
        cfg_cs = NB'($urandom_range(0, 6));
        if (cfg_saw && $urandom_range(0, 3) == 0) cfg_ce = NB'($urandom_range(0, int'(cfg_cs)));
        else cfg_ce = cfg_cs + NB'($urandom_range(0, 8));
        for (int k = 0; k < NC; k++) set_ch(k, $urandom_range(0, 15), $urandom_range(0, 7));
    endtask

    initial begin
        int ends;
        logic [NS-1:0] sv;
        clear_cfg();
        rstn = 1'b0;

        // reset state
        step();
        step();
        check("reset_counter", 32'(counter), 32'd0);
        check("reset_pwm_n", 32'(pwmn), 32'd0);
        rstn = 1'b1;

        // saw 0..9, ch0 SET_RST at 5
        cfg_ce = NB'(9);
        set_ch(0, 5, 2);
        pulse_start();
        run(40);

        // triangle 0..4, ch1 TOGGLE at 2
        do_reset();
        clear_cfg();
        cfg_saw = 1'b0; cfg_ce = NB'(4);
        set_ch(1, 2, 3);
        pulse_start();
        run(40);

        // rising edges on signal_i[7], prescaler 2, noise on other lines
        do_reset();
        clear_cfg();
        cfg_ce = NB'(200); cfg_mode = 3'd3; cfg_sel = 5'd7; cfg_presc = 8'd2;
        set_ch(0, 3, 3);
        pulse_start();
        for (int i = 0; i < 120; i++) begin
            sv = $urandom;
            sv[7] = sig[7] ^ ($urandom_range(0, 1) == 1);
            sig = sv;
            step();
        end
        run(20);

        // dead time 3 on toggling channels
        do_reset();
        clear_cfg();
        cfg_ce = NB'(9); cfg_dt = 8'd3;
        set_ch(0, 2, 3);
        set_ch(2, 7, 3);
        set_ch(3, 4, 1);
        pulse_start();
        run(60);

        // one-shot saw ending at 5, then restart
        do_reset();
        clear_cfg();
        cfg_ce = NB'(5); cfg_cs = NB'(1); cfg_oneshot = 1'b1;
        set_ch(0, 3, 2);
        pulse_start();
        ends = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            ends += int'(endo);
        end
        check("oneshot_end_count", 32'(ends), 32'd1);
        check("oneshot_counter_hold", 32'(counter), 32'd1);
        pulse_start();
        run(10);

        // shadow end 9 -> 3 requested mid-period, plus stop/rst/start+stop interplay
        do_reset();
        clear_cfg();
        cfg_ce = NB'(9);
        set_ch(0, 6, 2);
        pulse_start();
        run(4);
        cfg_ce = NB'(3); cfg_update = 1'b1;
        step();
        cfg_update = 1'b0;
        run(30);
        cfg_stop = 1'b1; step(); cfg_stop = 1'b0;
        run(3);
        cfg_rst = 1'b1; step(); cfg_rst = 1'b0;
        cfg_start = 1'b1; cfg_stop = 1'b1; step(); cfg_start = 1'b0; cfg_stop = 1'b0;
        pulse_start();
        run(6);

        // reset mid-run clears everything on the next cycle
        rstn = 1'b0;
        step();
        check("midrun_reset_pwm", 32'(pwm | pwmn), 32'd0);
        rstn = 1'b1;
        run(3);

        // randomized segments
        for (int seg = 0; seg < 12; seg++) begin
            do_reset();
            clear_cfg();
            cfg_saw     = ($urandom_range(0, 1) == 1);
            cfg_mode    = 3'($urandom_range(0, 7));
            cfg_sel     = 5'($urandom_range(0, 31));
            cfg_presc   = 8'($urandom_range(0, 2));
            cfg_dt      = 8'($urandom_range(0, 4));
            cfg_oneshot = ($urandom_range(0, 3) == 0);
            rand_shadow();
            pulse_start();
            for (int c = 0; c < 200; c++) begin
                sig        = $urandom;
                cfg_stop   = ($urandom_range(0, 49) == 0);
                cfg_start  = ($urandom_range(0, 19) == 0);
                cfg_rst    = ($urandom_range(0, 49) == 0);
                cfg_update = ($urandom_range(0, 19) == 0);
                if (cfg_update || $urandom_range(0, 29) == 0) rand_shadow();
                step();
                cfg_stop = 0; cfg_start = 0; cfg_rst = 0; cfg_update = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
